// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART frame arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_SYNC,
    ST_SEND_ID,
    ST_SEND_LEN,
    ST_SEND_DATA,
    ST_SEND_CSUM
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Header byte positions within a transmitted frame (SYNC is position 0).
  localparam int unsigned ID_POS  = 1;
  localparam int unsigned LEN_POS = 2;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_frame_buf.sv
// Frame payload buffer: synchronous write, combinational read.
module frame_buf
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] r_mem [DEPTH];

  // Store one payload byte per accepted write.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Out-of-range reads (one past the last byte) return zero.
  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) begin
      rdata = r_mem[raddr];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter feeding one UART byte transmitter.
// Loads a whole frame from the granted requester, then sends
// SYNC, ID, LEN, payload, XOR checksum paced on tx_rdy.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned MAXLEN = 16,
  parameter logic [7:0]  SYNC   = SYNC_DEFAULT,
  localparam int unsigned IDW   = clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_wen,
  output logic [7:0]        tx_din,
  input  logic              tx_rdy,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              trunc
);

  localparam int unsigned AW = (MAXLEN > 1) ? clog2(MAXLEN) : 1;

  state_t          r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_grant_id;
  logic [7:0]      r_len;
  logic [7:0]      r_csum;
  logic [7:0]      r_rd;
  logic [7:0]      r_tx_din;
  logic            r_gap;
  logic            r_trunc;
  logic [NREQ-1:0] r_req_ready;

  logic            w_found_hi;
  logic            w_found_lo;
  logic [IDW-1:0]  w_grant_hi;
  logic [IDW-1:0]  w_grant_lo;
  logic            w_found;
  logic [IDW-1:0]  w_grant;
  logic [NREQ-1:0] w_grant_1h;
  logic [7:0]      w_sel_data;
  logic            w_sel_valid;
  logic            w_sel_last;
  logic            w_accept;
  logic            w_frame_end;
  logic            w_send;
  logic            w_tx_wen;
  logic            w_last_data;
  logic [AW-1:0]   w_waddr;
  logic [AW-1:0]   w_raddr;
  logic [7:0]      w_rdata;
  logic [7:0]      w_id_byte;

  // Round-robin pick: lowest requester above rr_ptr, else lowest at or below it.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_grant_hi = '0;
    w_grant_lo = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        if (i > 32'(r_rr_ptr)) begin
          if (!w_found_hi) begin
            w_found_hi = 1'b1;
            w_grant_hi = IDW'(i);
          end
        end else if (!w_found_lo) begin
          w_found_lo = 1'b1;
          w_grant_lo = IDW'(i);
        end
      end
    end
    w_found = w_found_hi | w_found_lo;
    w_grant = w_found_hi ? w_grant_hi : w_grant_lo;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_grant_1h[i] = (IDW'(i) == w_grant);
    end
  end

  // Route the granted requester's byte lane.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == r_grant_id) begin
        w_sel_data  = req_data[i*8 +: 8];
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
      end
    end
  end

  assign w_accept    = (r_state == ST_LOAD) && w_sel_valid;
  assign w_frame_end = w_accept && (w_sel_last || (r_len == 8'(MAXLEN - 1)));
  assign w_send      = (r_state == ST_SEND_SYNC) || (r_state == ST_SEND_ID) ||
                       (r_state == ST_SEND_LEN)  || (r_state == ST_SEND_DATA) ||
                       (r_state == ST_SEND_CSUM);
  assign w_tx_wen    = w_send && tx_rdy && !r_gap;
  assign w_last_data = (r_rd == (r_len - 8'd1));
  assign w_id_byte   = 8'(r_grant_id);
  assign w_waddr     = AW'(r_len);
  // tx_din holds the byte about to go out, so the read port looks one ahead.
  assign w_raddr     = (r_state == ST_SEND_DATA) ? AW'(r_rd + 8'd1) : '0;

  frame_buf #(
    .DEPTH (MAXLEN),
    .AW    (AW)
  ) u_frame_buf (
    .clk   (CLK),
    .we    (w_accept),
    .waddr (w_waddr),
    .wdata (w_sel_data),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  // Frame FSM: grant, load, then walk the header/payload/checksum bytes.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= IDW'(NREQ - 1);
      r_grant_id  <= '0;
      r_len       <= '0;
      r_csum      <= '0;
      r_rd        <= '0;
      r_tx_din    <= '0;
      r_gap       <= 1'b0;
      r_trunc     <= 1'b0;
      r_req_ready <= '0;
    end else begin
      r_trunc <= 1'b0;
      r_gap   <= w_tx_wen;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_id  <= w_grant;
            r_rr_ptr    <= w_grant;
            r_len       <= '0;
            r_csum      <= '0;
            r_req_ready <= w_grant_1h;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_len  <= r_len + 8'd1;
            r_csum <= r_csum ^ w_sel_data;
            if (w_frame_end) begin
              r_req_ready <= '0;
              r_trunc     <= !w_sel_last;
              r_tx_din    <= SYNC;
              r_state     <= ST_SEND_SYNC;
            end
          end
        end
        ST_SEND_SYNC: begin
          if (w_tx_wen) begin
            r_tx_din <= w_id_byte;
            r_state  <= ST_SEND_ID;
          end
        end
        ST_SEND_ID: begin
          if (w_tx_wen) begin
            r_tx_din <= r_len;
            r_state  <= ST_SEND_LEN;
          end
        end
        ST_SEND_LEN: begin
          if (w_tx_wen) begin
            r_tx_din <= w_rdata;
            r_rd     <= '0;
            r_state  <= ST_SEND_DATA;
          end
        end
        ST_SEND_DATA: begin
          if (w_tx_wen) begin
            if (w_last_data) begin
              r_tx_din <= r_csum ^ w_id_byte ^ r_len;
              r_state  <= ST_SEND_CSUM;
            end else begin
              r_tx_din <= w_rdata;
              r_rd     <= r_rd + 8'd1;
            end
          end
        end
        ST_SEND_CSUM: begin
          if (w_tx_wen) begin
            r_tx_din <= '0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign tx_wen    = w_tx_wen;
  assign tx_din    = r_tx_din;
  assign busy      = (r_state != ST_IDLE);
  assign grant_id  = r_grant_id;
  assign trunc     = r_trunc;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a queue-based frame model.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int NREQ   = 4;
  localparam int MAXLEN = 4;
  localparam int IDW    = 2;
  localparam logic [7:0] SYNC_B = 8'hA5;

  logic              CLK = 1'b0;
  logic              RST_X = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_wen;
  logic [7:0]        tx_din;
  logic              tx_rdy;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              trunc;

  uart_tx_arbiter #(
    .NREQ   (NREQ),
    .MAXLEN (MAXLEN),
    .SYNC   (SYNC_B)
  ) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_wen    (tx_wen),
    .tx_din    (tx_din),
    .tx_rdy    (tx_rdy),
    .busy      (busy),
    .grant_id  (grant_id),
    .trunc     (trunc)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Producer streams: {last, data} per requester.
  logic [8:0] pq [NREQ][$];

  // Frame-level reference model.
  typedef enum int {M_IDLE, M_LOAD, M_SEND} mphase_t;
  mphase_t    m_phase;
  int         m_rr, m_grant, m_len;
  bit         m_gap, m_trunc;
  logic [7:0] m_pay [$];
  logic [7:0] m_out [$];

  // Environment knobs and logs.
  int         tx_busy, rdy_mode, vprob;
  bit         hold_low, use_pat, prev_busy;
  logic [7:0] pat;
  logic [7:0] txlog [$];
  int         glog [$];
  int         trunc_cnt, cyc, last_wen;

  logic [7:0] exp1 [6] = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
  int         expg [7] = '{0, 2, 3, 0, 2, 3, 3};

  function automatic logic [31:0] txat(input int i);
    if (i < txlog.size()) return 32'(txlog[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] gat(input int i);
    if (i < glog.size()) return 32'(glog[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic bit queues_empty();
    for (int r = 0; r < NREQ; r++) if (pq[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    pq[r].push_back({last, d});
  endtask

  task automatic push_rand_frame(input int r, input int len);
    for (int i = 0; i < len; i++) push_byte(r, 8'($urandom), i == len - 1);
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    m_rr = NREQ - 1;
    m_grant = 0;
    m_len = 0;
    m_gap = 0;
    m_trunc = 0;
    m_pay.delete();
    m_out.delete();
    tx_busy = 0;
    hold_low = 0;
    use_pat = 0;
    prev_busy = 0;
    for (int r = 0; r < NREQ; r++) pq[r].delete();
  endtask

  // One clock cycle: drive at negedge, check, then advance the model.
  task automatic step();
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] one;
    bit              exp_wen;
    bit              v;
    int              found;
    logic [8:0]      b;
    logic [7:0]      hdr [3];
    logic [7:0]      chk;
    @(negedge CLK);
    for (int r = 0; r < NREQ; r++) begin
      v = (pq[r].size() > 0) && ($urandom_range(99) < vprob);
      if (use_pat && m_phase == M_LOAD && r == m_grant) v = (pq[r].size() > 0) && pat[0];
      req_valid[r] = v;
      if (pq[r].size() > 0) begin
        req_data[r*8 +: 8] = pq[r][0][7:0];
        req_last[r]        = pq[r][0][8];
      end else begin
        req_data[r*8 +: 8] = 8'($urandom);
        req_last[r]        = 1'($urandom);
      end
    end
    tx_rdy = (tx_busy == 0) && !hold_low && (rdy_mode == 0 || $urandom_range(3) != 0);
    #1;
    one       = 1;
    exp_ready = (m_phase == M_LOAD) ? (one << m_grant) : '0;
    exp_wen   = (m_phase == M_SEND) && tx_rdy && !m_gap;
    check_eq("busy", busy, m_phase != M_IDLE);
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("tx_wen", tx_wen, exp_wen);
    check_eq("grant_id", grant_id, m_grant);
    check_eq("trunc", trunc, m_trunc);
    if (exp_wen) check_eq("tx_din", tx_din, m_out[0]);
    if (tx_wen) begin
      txlog.push_back(tx_din);
      if (last_wen >= 0) check_eq("wen_spacing", (cyc - last_wen) >= 2, 1);
      last_wen = cyc;
    end
    if (trunc) trunc_cnt++;
    if (busy && !prev_busy) glog.push_back(int'(grant_id));
    prev_busy = busy;

    m_trunc = 0;
    m_gap   = exp_wen;
    case (m_phase)
      M_IDLE: begin
        found = -1;
        for (int k = 1; k <= NREQ; k++)
          if (found < 0 && req_valid[(m_rr + k) % NREQ]) found = (m_rr + k) % NREQ;
        if (found >= 0) begin
          m_grant = found;
          m_rr    = found;
          m_pay.delete();
          m_phase = M_LOAD;
        end
      end
      M_LOAD: begin
        if (req_valid[m_grant]) begin
          b = pq[m_grant].pop_front();
          m_pay.push_back(b[7:0]);
          if (b[8] || m_pay.size() == MAXLEN) begin
            m_len = m_pay.size();
            hdr[0]       = SYNC_B;
            hdr[ID_POS]  = 8'(m_grant);
            hdr[LEN_POS] = 8'(m_len);
            chk = hdr[ID_POS] ^ hdr[LEN_POS];
            foreach (m_pay[i]) chk ^= m_pay[i];
            m_out.delete();
            for (int i = 0; i < 3; i++) m_out.push_back(hdr[i]);
            foreach (m_pay[i]) m_out.push_back(m_pay[i]);
            m_out.push_back(chk);
            m_trunc = !b[8];
            m_phase = M_SEND;
          end
        end
        if (use_pat) pat = pat >> 1;
      end
      M_SEND: begin
        if (exp_wen) begin
          void'(m_out.pop_front());
          if (m_out.size() == 0) m_phase = M_IDLE;
        end
      end
      default: m_phase = M_IDLE;
    endcase
    if (tx_busy > 0) tx_busy--;
    if (tx_wen) tx_busy = (rdy_mode == 0) ? 1 : int'($urandom_range(1, 3));
    cyc++;
  endtask

  task automatic run_until_idle(input int maxc, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_phase == M_IDLE && queues_empty()) && n < maxc);
    check_eq({tag, "_done"}, n < maxc, 1);
  endtask

  // Asynchronous reset, applied between clock edges.
  task automatic do_reset();
    #1;
    RST_X = 1'b0;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wen", tx_wen, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_din", tx_din, 0);
    check_eq("rst_grant", grant_id, 0);
    check_eq("rst_trunc", trunc, 0);
    req_valid = '0;
    tx_rdy    = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      #1;
      check_eq("rst_hold_wen", tx_wen, 0);
    end
    model_reset();
    @(negedge CLK);
    RST_X = 1'b1;
  endtask

  initial begin
    int n;
    logic [7:0] first;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_rdy    = 1'b1;
    vprob     = 100;
    rdy_mode  = 0;
    cyc       = 0;
    last_wen  = -100;
    trunc_cnt = 0;
    do_reset();

    // Single frame from requester 1, transmitter always ready.
    txlog.delete();
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h22, 1'b1);
    run_until_idle(100, "single");
    check_eq("single_count", txlog.size(), 6);
    for (int i = 0; i < 6; i++) check_eq($sformatf("single_b%0d", i), txat(i), 32'(exp1[i]));

    // Round robin over 0/2/3, then wrap back to 3 alone.
    do_reset();
    glog.delete();
    for (int rep = 0; rep < 2; rep++) begin
      push_rand_frame(0, 1);
      push_rand_frame(2, 1);
      push_rand_frame(3, 1);
    end
    run_until_idle(300, "rr");
    push_rand_frame(3, 1);
    run_until_idle(100, "rr_wrap");
    check_eq("rr_count", glog.size(), 7);
    for (int i = 0; i < 7; i++) check_eq($sformatf("rr_g%0d", i), gat(i), 32'(expg[i]));

    // Truncation: 6 bytes against MAXLEN=4.
    txlog.delete();
    trunc_cnt = 0;
    push_rand_frame(0, 6);
    run_until_idle(300, "trunc");
    check_eq("trunc_pulses", trunc_cnt, 1);
    check_eq("trunc_count", txlog.size(), 14);
    check_eq("trunc_len1", txat(2), 4);
    check_eq("trunc_sync2", txat(8), 32'(SYNC_B));
    check_eq("trunc_len2", txat(10), 2);

    // Backpressure while LEN is pending.
    push_rand_frame(2, 3);
    n = 0;
    while (!(m_phase == M_SEND && m_out.size() == m_len + 2) && n < 100) begin
      step();
      n++;
    end
    check_eq("bp_reach", n < 100, 1);
    hold_low = 1;
    step();
    first = tx_din;
    check_eq("bp_din_len", first, 3);
    for (int i = 0; i < 19; i++) begin
      step();
      check_eq("bp_din_stable", tx_din, first);
    end
    hold_low = 0;
    step();
    check_eq("bp_resume_wen", tx_wen, 1);
    check_eq("bp_resume_din", tx_din, 3);
    run_until_idle(100, "bp");

    // Stalled producer: valid 1,0,0,1 during LOAD.
    txlog.delete();
    use_pat = 1;
    pat = 8'b0000_1001;
    push_byte(1, 8'h33, 1'b0);
    push_byte(1, 8'h44, 1'b1);
    run_until_idle(100, "stall");
    use_pat = 0;
    check_eq("stall_count", txlog.size(), 6);
    check_eq("stall_id", txat(1), 1);
    check_eq("stall_len", txat(2), 2);
    check_eq("stall_chk", txat(5), 32'(8'h01 ^ 8'h02 ^ 8'h33 ^ 8'h44));

    // Random traffic with a lagging transmitter.
    rdy_mode = 1;
    vprob = 70;
    for (int f = 0; f < 16; f++) push_rand_frame(int'($urandom_range(NREQ - 1)), int'($urandom_range(1, 6)));
    run_until_idle(4000, "random");

    // Reset in the middle of SEND_DATA.
    rdy_mode = 0;
    vprob = 100;
    push_rand_frame(1, 4);
    n = 0;
    while (!(m_phase == M_SEND && m_out.size() == m_len) && n < 100) begin
      step();
      n++;
    end
    check_eq("mid_reach", n < 100, 1);
    do_reset();
    glog.delete();
    for (int r = 0; r < NREQ; r++) push_rand_frame(r, 1);
    run_until_idle(200, "post_rst");
    check_eq("post_rst_first", gat(0), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin frame arbiter that shares one UART byte transmitter (wen/din/rdy interface) between NREQ requesters. It accepts one whole frame from the granted requester into a local buffer. It then sends the frame as SYNC, ID, LEN, payload and XOR checksum, pacing every byte on the transmitter's ready. It sits between on-chip byte producers and the serial transmitter.

## Interface
- NREQ, 4: number of requesters, 2..16
- MAXLEN, 16: maximum payload bytes per frame, 1..255
- SYNC, 8'hA5: frame start byte
- IDW, derived, clog2(NREQ): width of grant_id
- CLK  in  1  system clock
- RST_X  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  NREQ*8  per-requester byte; requester i on bits [8i+7:8i]
- req_last  in  NREQ  marks the final payload byte of the frame
- req_ready  out  NREQ  byte accepted on valid&ready; one-hot or zero
- tx_wen  out  1  single-cycle byte-write strobe to the transmitter
- tx_din  out  8  byte to transmit; valid while tx_wen=1
- tx_rdy  in  1  transmitter idle; goes low the cycle after an accepted tx_wen
- busy  out  1  high from LOAD through SEND_CSUM
- grant_id  out  IDW  current/last granted requester
- trunc  out  1  one-cycle pulse when a frame is cut at MAXLEN

## Operation
- States: IDLE, LOAD, SEND_SYNC, SEND_ID, SEND_LEN, SEND_DATA, SEND_CSUM.
- IDLE: if any req_valid is set, grant the first requester searching from rr_ptr+1 upward with wrap. Set grant_id, rr_ptr <= grant, clear len/csum, go to LOAD. Otherwise stay.
- LOAD: req_ready[grant]=1. Each accepted byte is written to buf[len], len++, csum ^= byte. Go to SEND_SYNC on an accepted byte with req_last=1, or on the MAXLEN-th accepted byte. If that MAXLEN-th byte has req_last=0, pulse trunc. The remaining bytes form the requester's next frame.
- SEND_* states: tx_wen = tx_rdy & ~gap. On tx_wen, advance to the next byte and set gap for one cycle.
- Byte order on tx_din: SYNC, then {0, grant_id} as ID, then len as LEN (1..MAXLEN), then buf[0..len-1], then CHK = ID ^ LEN ^ all payload bytes.
- SEND_DATA uses an internal index rd from 0 to len-1 and leaves after the byte with rd=len-1.
- On the CHK tx_wen, go to IDLE.
- Single buffer: no LOAD while sending. Requesters stall until the next grant.
- Frames are never empty. A requester cannot lose a grant mid-frame.
- req_valid from non-granted requesters is ignored. Their req_ready stays 0.
- Reset (async, any state): state IDLE, rr_ptr=NREQ-1 so requester 0 wins first. tx_wen=0, tx_din=0, req_ready=0, busy=0, grant_id=0, trunc=0, gap=0, len=0, csum=0. Buffer contents are don't-care. A partially loaded or sent frame is abandoned with no resumption.

## Timing
- Requests seen in IDLE at cycle t give req_ready at t+1, so arbitration latency is 1 cycle.
- LOAD accepts one byte per cycle. An L-byte frame with continuous valid takes L cycles.
- The last accepted byte at cycle u puts the block in SEND_SYNC at u+1. tx_wen fires at u+1 if tx_rdy=1.
- Consecutive tx_wen strobes are at least 2 cycles apart, which covers the transmitter's 1-cycle rdy lag. tx_wen is never asserted while tx_rdy=0.
- A frame is len+4 transmitter bytes.
- IDLE is entered the cycle after the CHK strobe. The earliest next req_ready is 2 cycles after the CHK strobe.
- trunc is asserted in the cycle after the truncating byte, i.e. the first SEND_SYNC cycle.
- busy is combinational from state (state≠IDLE). All other outputs are registered except tx_wen, which is gated by tx_rdy.

## Structure
- Shared package holds:
  - the state enum;
  - the SYNC default;
  - a clog2 function;
  - the constants ID_POS/LEN_POS, which give the header byte order.
- Sub-module frame_buf: MAXLEN×8 register/RAM buffer.
  - Write port: we, waddr, wdata.
  - Combinational read port: raddr → rdata.
- Arbiter, FSM and checksum stay in uart_tx_arbiter.

## Test plan
- Single frame, tx_rdy tied high: req1 sends 0x11, 0x22(last). Required tx_din sequence is A5, 01, 02, 11, 22, 30. Exactly 6 tx_wen pulses, each ≥2 cycles apart; busy then drops.
- Round robin: req0, req2 and req3 hold valid continuously with 1-byte frames. Required grant order is 0, 2, 3, 0. Next, only req3 is valid with rr_ptr=3: it is regranted immediately, testing wrap.
- Truncation with MAXLEN=4: req0 streams 6 bytes with last only on byte 6. Required response is LEN=04 on the first frame with trunc pulsed once. A second frame follows with LEN=02, provided req0 still wins arbitration.
- Backpressure: hold tx_rdy low for 20 cycles in SEND_LEN. Required: no tx_wen during the hold, and tx_din/state are stable. LEN is sent on the first cycle tx_rdy returns.
- Stalled producer: in LOAD, req_valid toggles 1,0,0,1(last). Required: only 2 bytes are buffered, LEN=02, and the checksum is correct.
- Reset mid-SEND_DATA: drop RST_X asynchronously. Required: all outputs reach their reset values immediately with no further tx_wen. After release, requester 0 wins first arbitration.
